// File: rtl/vga_pkg.sv
// vga_pkg: shared resolution constants and state type
// for the VGA demo pixel generators.
package vga_pkg;

`ifdef VGA_RES_160
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int XMAX = 160;
  localparam int YMAX = 120;
`elsif VGA_RES_320
  localparam int XW   = 9;
  localparam int YW   = 8;
  localparam int XMAX = 320;
  localparam int YMAX = 240;
`else
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int XMAX = 640;
  localparam int YMAX = 480;
`endif

  localparam int CW = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } rect_state_t;

endpackage

// File: rtl/vga_raster_counter.sv
// vga_raster_counter: row-major x/y walker over a
// base+extent window, flags the final position.
module vga_raster_counter #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [XW-1:0] base_x,
  input  logic [YW-1:0] base_y,
  input  logic [XW:0]   ext_x,
  input  logic [YW:0]   ext_y,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last
);

  localparam logic [XW:0]   ONE_XE = (XW+1)'(1);
  localparam logic [YW:0]   ONE_YE = (YW+1)'(1);
  localparam logic [YW-1:0] ONE_Y  = YW'(1);
  localparam logic [XW-1:0] ONE_X  = XW'(1);

  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [XW-1:0] bx_q, bx_d;
  logic [XW-1:0] ex_q, ex_d;
  logic [YW-1:0] ey_q, ey_d;

  // load window corners or step one pixel, wrapping rows
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    bx_d = bx_q;
    ex_d = ex_q;
    ey_d = ey_q;
    if (load) begin
      cx_d = base_x;
      cy_d = base_y;
      bx_d = base_x;
      ex_d = XW'({1'b0, base_x} + ext_x - ONE_XE);
      ey_d = YW'({1'b0, base_y} + ext_y - ONE_YE);
    end else if (en) begin
      if (cx_q == ex_q) begin
        cx_d = bx_q;
        cy_d = cy_q + ONE_Y;
      end else begin
        cx_d = cx_q + ONE_X;
      end
    end
  end

  // position and window registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q <= '0;
      cy_q <= '0;
      bx_q <= '0;
      ex_q <= '0;
      ey_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
      bx_q <= bx_d;
      ex_q <= ex_d;
      ey_q <= ey_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == ex_q) && (cy_q == ey_q);

endmodule

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rasterises one clipped filled rectangle
// per request into the VGA pixel write stream.
module vga_rect_fill #(
  parameter int XW   = vga_pkg::XW,
  parameter int YW   = vga_pkg::YW,
  parameter int XMAX = vga_pkg::XMAX,
  parameter int YMAX = vga_pkg::YMAX,
  parameter int CW   = vga_pkg::CW
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  input  logic [CW-1:0] color,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] VGA_X,
  output logic [YW-1:0] VGA_Y,
  output logic [CW-1:0] VGA_COLOR,
  output logic          plot
);

  import vga_pkg::*;

  localparam logic [XW:0] XLIM = (XW+1)'(XMAX);
  localparam logic [YW:0] YLIM = (YW+1)'(YMAX);

  rect_state_t state_q, state_d;

  logic [XW-1:0] rx_q, rx_d;
  logic [YW-1:0] ry_q, ry_d;
  logic [XW-1:0] rw_q, rw_d;
  logic [YW-1:0] rh_q, rh_d;
  logic [CW-1:0] rc_q, rc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          plot_q, plot_d;

  logic [XW:0]   x_room, we;
  logic [YW:0]   y_room, he;
  logic          empty;
  logic          cnt_load, cnt_en, cnt_last;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;

  // clip the latched request against the screen edges
  always_comb begin
    x_room = XLIM - {1'b0, rx_q};
    y_room = YLIM - {1'b0, ry_q};
    we = ({1'b0, rw_q} < x_room) ? {1'b0, rw_q} : x_room;
    he = ({1'b0, rh_q} < y_room) ? {1'b0, rh_q} : y_room;
    empty = ({1'b0, rx_q} >= XLIM) ||
            ({1'b0, ry_q} >= YLIM) ||
            (rw_q == '0) || (rh_q == '0);
  end

  // request FSM: next state, latches and output values
  always_comb begin
    state_d  = state_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    rw_d     = rw_q;
    rh_d     = rh_q;
    rc_d     = rc_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rx_d    = x0;
          ry_d    = y0;
          rw_d    = w;
          rh_d    = h;
          rc_d    = color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (empty) begin
          state_d = DONE;
        end else begin
          cnt_load = 1'b1;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SETUP) || (state_d == DRAW);
    done_d = (state_d == DONE);
    plot_d = (state_d == DRAW);
    vc_d   = cnt_load ? rc_q : vc_q;
  end

  // state, request latches and registered outputs
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rx_q    <= '0;
      ry_q    <= '0;
      rw_q    <= '0;
      rh_q    <= '0;
      rc_q    <= '0;
      vc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rw_q    <= rw_d;
      rh_q    <= rh_d;
      rc_q    <= rc_d;
      vc_q    <= vc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plot_q  <= plot_d;
    end
  end

  vga_raster_counter #(
    .XW(XW),
    .YW(YW)
  ) u_cnt (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .load   (cnt_load),
    .en     (cnt_en),
    .base_x (rx_q),
    .base_y (ry_q),
    .ext_x  (we),
    .ext_y  (he),
    .cx     (cnt_x),
    .cy     (cnt_y),
    .last   (cnt_last)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign plot      = plot_q;
  assign VGA_X     = cnt_x;
  assign VGA_Y     = cnt_y;
  assign VGA_COLOR = vc_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: directed rectangle requests checked
// against a per-cycle pixel timeline model.
module tb_vga_rect_fill;

  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int XMAX = 640;
  localparam int YMAX = 480;
  localparam int CW   = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] x0 = '0;
  logic [YW-1:0] y0 = '0;
  logic [XW-1:0] w = '0;
  logic [YW-1:0] h = '0;
  logic [CW-1:0] color = '0;
  logic          busy, done, plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_c;

  always #5 clk = ~clk;

  vga_rect_fill #(
    .XW(XW), .YW(YW), .XMAX(XMAX), .YMAX(YMAX), .CW(CW)
  ) dut (
    .CLOCK_50  (clk),
    .resetn    (rst_n),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .color     (color),
    .busy      (busy),
    .done      (done),
    .VGA_X     (vga_x),
    .VGA_Y     (vga_y),
    .VGA_COLOR (vga_c),
    .plot      (plot)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_on = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // expected output timeline: one record per cycle
  typedef struct {
    bit busy; bit done; bit plot;
    int x; int y; int col;
  } rec_t;
  rec_t q[$];
  rec_t e;

  task automatic plan(int ax, int ay, int aw, int ah,
                      int acol);
    rec_t r;
    int xe, ye;
    r = e;
    r.busy = 1; r.done = 0; r.plot = 0;
    e = r;
    xe = (ax + aw > XMAX) ? XMAX : ax + aw;
    ye = (ay + ah > YMAX) ? YMAX : ay + ah;
    if (ax < XMAX && ay < YMAX && aw > 0 && ah > 0) begin
      for (int yy = ay; yy < ye; yy++)
        for (int xx = ax; xx < xe; xx++) begin
          r.busy = 1; r.done = 0; r.plot = 1;
          r.x = xx; r.y = yy; r.col = acol;
          q.push_back(r);
        end
    end
    r.busy = 0; r.done = 1; r.plot = 0;
    q.push_back(r);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      e = '{default: 0};
    end else if (q.size() > 0) begin
      e = q.pop_front();
    end else if (e.done) begin
      e.done = 0;
    end else if (start) begin
      plan(int'(x0), int'(y0), int'(w), int'(h),
           int'(color));
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("plot", plot, e.plot);
      chk("vga_x", vga_x, e.x);
      chk("vga_y", vga_y, e.y);
      chk("vga_color", vga_c, e.col);
    end
  end

  int px_x[$], px_y[$], px_c[$], px_t[$];
  int n_done = 0, t_done = 0, n_busy = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (plot) begin
        px_x.push_back(int'(vga_x));
        px_y.push_back(int'(vga_y));
        px_c.push_back(int'(vga_c));
        px_t.push_back(cyc);
      end
      if (done) begin
        n_done++;
        t_done = cyc;
      end
      if (busy) n_busy++;
    end
  end

  int t_start = 0;

  task automatic clr();
    px_x.delete(); px_y.delete();
    px_c.delete(); px_t.delete();
    n_done = 0; t_done = 0; n_busy = 0;
  endtask

  task automatic drive_start(int ax, int ay, int aw,
                             int ah, int acol);
    @(negedge clk); #1;
    clr();
    x0 = XW'(ax); y0 = YW'(ay);
    w = XW'(aw); h = YW'(ah);
    color = CW'(acol);
    start = 1'b1;
    t_start = cyc + 1;
    @(negedge clk); #1;
    start = 1'b0;
    x0 = XW'($urandom); y0 = YW'($urandom);
    w = XW'($urandom); h = YW'($urandom);
    color = CW'($urandom);
  endtask

  task automatic wait_done(int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk); #1;
      if (n_done > 0) seen = 1;
    end
    chk("done_seen", seen, 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic run_req(int ax, int ay, int aw, int ah,
                         int acol, int limit);
    drive_start(ax, ay, aw, ah, acol);
    wait_done(limit);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1;
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_col", vga_c, 0);

    run_req(10, 20, 3, 2, 'hFF0000, 50);
    chk("t1_count", px_x.size(), 6);
    chk("t1_p0x", px_x[0], 10);
    chk("t1_p0y", px_y[0], 20);
    chk("t1_p2x", px_x[2], 12);
    chk("t1_p3x", px_x[3], 10);
    chk("t1_p3y", px_y[3], 21);
    chk("t1_p5x", px_x[5], 12);
    chk("t1_p5y", px_y[5], 21);
    chk("t1_col", px_c[5], 'hFF0000);
    chk("t1_first", px_t[0] - t_start, 1);
    chk("t1_span", px_t[5] - px_t[0], 5);
    chk("t1_done_lat", t_done - px_t[5], 1);
    chk("t1_ndone", n_done, 1);
    chk("t1_busy", n_busy, 7);

    run_req(638, 478, 5, 5, 'h00FF00, 50);
    chk("clip_count", px_x.size(), 4);
    chk("clip_p1x", px_x[1], 639);
    chk("clip_p2y", px_y[2], 479);
    chk("clip_p3x", px_x[3], 639);
    chk("clip_p3y", px_y[3], 479);
    chk("clip_done_lat", t_done - px_t[3], 1);

    run_req(5, 5, 0, 3, 'h123456, 20);
    chk("w0_count", px_x.size(), 0);
    chk("w0_done_lat", t_done - t_start, 1);
    chk("w0_busy", n_busy, 1);

    run_req(700, 5, 4, 3, 'h654321, 20);
    chk("x700_count", px_x.size(), 0);
    chk("x700_done_lat", t_done - t_start, 1);
    chk("x700_busy", n_busy, 1);

    drive_start(100, 100, 4, 4, 'h00FF00);
    repeat (5) @(negedge clk);
    #1;
    x0 = 10'd7; y0 = 9'd7; w = 10'd2; h = 9'd2;
    color = 24'h0000FF;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(60);
    repeat (30) @(negedge clk);
    #1;
    chk("rep_count", px_x.size(), 16);
    chk("rep_col", px_c[15], 'h00FF00);
    chk("rep_lastx", px_x[15], 103);
    chk("rep_lasty", px_y[15], 103);
    chk("rep_ndone", n_done, 1);

    drive_start(50, 60, 4, 4, 'h123456);
    repeat (3) @(negedge clk);
    #2;
    chk("abort_pre_plot", plot, 1);
    chk("abort_pre_x", vga_x, 52);
    rst_n = 1'b0;
    #1;
    chk("abort_plot", plot, 0);
    chk("abort_x", vga_x, 0);
    chk("abort_y", vga_y, 0);
    chk("abort_col", vga_c, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_ndone", n_done, 0);
    run_req(1, 2, 2, 2, 'hABCDEF, 30);
    chk("post_count", px_x.size(), 4);
    chk("post_p3x", px_x[3], 2);
    chk("post_p3y", px_y[3], 3);
    chk("post_col", px_c[0], 'hABCDEF);

    run_req(0, 470, 1023, 511, 'h0F0F0F, 10000);
    chk("wide_count", px_x.size(), 6400);
    chk("wide_p639x", px_x[639], 639);
    chk("wide_p640x", px_x[640], 0);
    chk("wide_p640y", px_y[640], 471);
    chk("wide_lastx", px_x[6399], 639);
    chk("wide_lasty", px_y[6399], 479);
    chk("wide_span", px_t[6399] - px_t[0], 6399);
    chk("wide_ndone", n_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
